// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Frames an incoming byte stream (sync, word count, 4-byte words, optional
// checksum) into ROM programming cycles: holds the ROM in edit mode for the
// whole load, assembles each 32-bit instruction little-endian and issues one
// send strobe per word with a line address advancing by STEP.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   -> a trailing XOR-of-payload byte is checked in a CHK state
//   undefined -> frame ends at DONE right after the last word is sent
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous reset, active-low
//   in_data[7:0]  stream byte
//   in_valid      in_data is valid
//   in_ready      loader accepts a byte (transfer on in_valid & in_ready)
//   edit          ROM edit enable, high while a load is in progress
//   line[7:0]     ROM line address of the current word
//   code[31:0]    assembled instruction, code[7:0] = opcode byte
//   send          one-cycle ROM write strobe
//   rom_clear     one-cycle pulse at frame start (ROM reset)
//   busy          high outside IDLE, DONE and ERR
//   done          one-cycle pulse on successful completion
//   error         high while in ERR
//   words_loaded  send strobes issued in the current frame
// ---------------------------------------------------------------------------
module program_loader #(
    parameter int unsigned STEP      = 4,
    parameter int unsigned MAX_WORDS = 64,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        edit,
    output logic [7:0]  line,
    output logic [31:0] code,
    output logic        send,
    output logic        rom_clear,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  words_loaded
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CODE_W = 32;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_SEND,
        S_DONE,
        S_ERR
`ifdef LOADER_CHECKSUM_EN
        ,
        S_CHK
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    b_q, b_d;
    logic [BYTE_W-1:0]   n_q, n_d;
    logic [BYTE_W-1:0]   line_q, line_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [BYTE_W-1:0]   words_q, words_d;
`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]   chk_q, chk_d;
`endif
    logic                clear_d;
    logic                accept;
    logic                is_sync;

    // Output registers, all derived from the next state
    logic in_ready_q, edit_q, send_q, rom_clear_q, busy_q, done_q, error_q;

    assign accept  = in_valid & in_ready_q;
    assign is_sync = (in_data == SYNC_BYTE);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            b_q         <= '0;
            n_q         <= '0;
            line_q      <= '0;
            code_q      <= '0;
            words_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_q       <= '0;
`endif
            in_ready_q  <= 1'b1;
            edit_q      <= 1'b0;
            send_q      <= 1'b0;
            rom_clear_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            b_q         <= b_d;
            n_q         <= n_d;
            line_q      <= line_d;
            code_q      <= code_d;
            words_q     <= words_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
            // Only SEND blocks the stream; DONE already behaves like IDLE
            in_ready_q  <= (state_d != S_SEND);
            send_q      <= (state_d == S_SEND);
            rom_clear_q <= clear_d;
            done_q      <= (state_d == S_DONE);
            error_q     <= (state_d == S_ERR);
            edit_q      <= (state_d != S_IDLE) && (state_d != S_ERR);
            busy_q      <= (state_d != S_IDLE) && (state_d != S_ERR) &&
                           (state_d != S_DONE);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        n_d     = n_q;
        line_d  = line_q;
        code_d  = code_q;
        words_d = words_q;
`ifdef LOADER_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        clear_d = 1'b0;

        unique case (state_q)
            // Waiting for a frame; non-sync bytes are dropped
            S_IDLE, S_DONE, S_ERR: begin
                if (accept && is_sync) begin
                    state_d = S_LEN;
                    clear_d = 1'b1;
                    line_d  = '0;
                    words_d = '0;
                    b_d     = '0;
`ifdef LOADER_CHECKSUM_EN
                    chk_d   = '0;
`endif
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end

            S_LEN: begin
                if (accept) begin
                    if ((in_data == '0) || (32'(in_data) > MAX_WORDS)) begin
                        state_d = S_ERR;
                    end else begin
                        n_d     = in_data;
                        b_d     = '0;
                        state_d = S_DATA;
                    end
                end
            end

            // Little-endian assembly; a sync byte here is ordinary payload
            S_DATA: begin
                if (accept) begin
                    code_d[{b_q, 3'b000} +: BYTE_W] = in_data;
`ifdef LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ in_data;
`endif
                    b_d = b_q + IDX_W'(1);
                    if (b_q == IDX_W'(3)) begin
                        state_d = S_SEND;
                    end
                end
            end

            // Single strobe cycle; address/count advance on leaving it
            S_SEND: begin
                line_d  = line_q + BYTE_W'(STEP);
                words_d = words_q + BYTE_W'(1);
                b_d     = '0;
                if (words_d == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end

`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    state_d = (in_data == chk_q) ? S_DONE : S_ERR;
                end
            end
`endif

            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready     = in_ready_q;
    assign edit         = edit_q;
    assign line         = line_q;
    assign code         = code_q;
    assign send         = send_q;
    assign rom_clear    = rom_clear_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
// Table-driven frame vectors plus hand-written latency and mid-frame reset
// sequences for program_loader. Honours LOADER_CHECKSUM_EN like the RTL.
// ---------------------------------------------------------------------------
module tb_program_loader;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready, edit, send, rom_clear, busy, done, error;
    logic [7:0]  line, words_loaded;
    logic [31:0] code;

    program_loader dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .edit         (edit),
        .line         (line),
        .code         (code),
        .send         (send),
        .rom_clear    (rom_clear),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame vector: raw bytes right-aligned; a trailing checksum byte is
    // dropped when the checksum feature is off.
    typedef struct packed {
        logic [7:0]   nbytes;
        logic [119:0] bytes;      // byte k at [119-8k -: 8]
        logic [7:0]   gapmax;
        logic [7:0]   nsend;
        logic [63:0]  codes;      // word k at [63-32k -: 32]
        logic [15:0]  lines;      // word k at [15-8k -: 8]
        logic         exp_done;
        logic         exp_err;
        logic [7:0]   words;
        logic [7:0]   clears;
    } vec_t;

    function automatic vec_t mk(input int total, input bit has_ck, input logic [119:0] raw,
                                input int gap, input int ns, input logic [63:0] cs,
                                input logic [15:0] ls, input bit d, input bit e,
                                input int w, input int c);
        vec_t v;
        int   used;
        used       = (has_ck && !CK_EN) ? total - 1 : total;
        v.nbytes   = 8'(used);
        v.bytes    = raw << (8 * (15 - total));
        v.gapmax   = 8'(gap);
        v.nsend    = 8'(ns);
        v.codes    = cs;
        v.lines    = ls;
        v.exp_done = d;
        v.exp_err  = e;
        v.words    = 8'(w);
        v.clears   = 8'(c);
        return v;
    endfunction

    // Monitor: collect strobes and check the in_ready/send relationship
    logic [31:0] codeq[$];
    logic [7:0]  lineq[$];
    int          done_cnt = 0;
    int          clr_cnt  = 0;
    bit          mon_en   = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (send) begin
                codeq.push_back(code);
                lineq.push_back(line);
                check("edit_during_send", 32'(edit), 32'd1);
            end
            if (done)      done_cnt++;
            if (rom_clear) clr_cnt++;
            if (in_ready !== ~send)
                check("in_ready_vs_send", 32'(in_ready), 32'(~send));
        end
    end

    // Offer one byte after 'gap' idle cycles; return just after it transfers
    task automatic put(input logic [7:0] b, input int gap);
        int guard;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic clear_mon();
        codeq.delete();
        lineq.delete();
        done_cnt = 0;
        clr_cnt  = 0;
    endtask

    vec_t vecs[8];
    int   nv;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(11, 1, 120'({8'hA5, 8'h02, 8'h18, 24'h0, 8'h1A, 24'h0, 8'h02}),
                     0, 2, {32'h18, 32'h1A}, {8'd0, 8'd4}, 1, 0, 2, 1);
        vecs[1] = mk(2, 0, 120'({8'hA5, 8'h00}), 0, 0, 64'h0, 16'h0, 0, 1, 0, 1);
        vecs[2] = mk(2, 0, 120'({8'h11, 8'h22}), 0, 0, 64'h0, 16'h0, 0, 1, 0, 0);
        vecs[3] = mk(7, 1, 120'({8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44}),
                     0, 1, {32'h44332211, 32'h0}, 16'h0, 1, 0, 1, 1);
        vecs[4] = mk(4, 0, 120'({8'hA5, 8'h41, 8'h11, 8'h22}), 0, 0, 64'h0, 16'h0, 0, 1, 0, 1);
        vecs[5] = mk(11, 1, 120'({8'hA5, 8'h02, 8'h18, 24'h0, 8'h1A, 24'h0, 8'h02}),
                     5, 2, {32'h18, 32'h1A}, {8'd0, 8'd4}, 1, 0, 2, 1);
        vecs[6] = mk(7, 1, 120'({8'hA5, 8'h01, 8'hA5, 8'h00, 8'h00, 8'hA5, 8'h00}),
                     0, 1, {32'hA50000A5, 32'h0}, 16'h0, 1, 0, 1, 1);
        vecs[7] = mk(7, 0, 120'({8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF}),
                     0, 1, {32'h04030201, 32'h0}, 16'h0, 0, 1, 1, 1);
        nv = CK_EN ? 8 : 7;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_edit", 32'(edit), 32'd0);
        check("rst_line", 32'(line), 32'd0);
        check("rst_code", code, 32'd0);
        check("rst_send", 32'(send), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        rst    = 1'b1;
        mon_en = 1'b1;

        // Send latency: strobe in the cycle after the 4th word byte
        put(8'hA5, 0);
        check("lat_rom_clear", 32'(rom_clear), 32'd1);
        check("lat_edit", 32'(edit), 32'd1);
        put(8'h01, 0);
        put(8'hDE, 0);
        put(8'hAD, 0);
        put(8'hBE, 0);
        put(8'hEF, 0);
        check("lat_send", 32'(send), 32'd1);
        check("lat_in_ready", 32'(in_ready), 32'd0);
        check("lat_code", code, 32'hEFBEADDE);
        check("lat_line", 32'(line), 32'd0);
        check("lat_busy", 32'(busy), 32'd1);
`ifdef LOADER_CHECKSUM_EN
        @(posedge clk); #1;
        check("lat_send_off", 32'(send), 32'd0);
        put(8'h22, 0);
`else
        @(posedge clk); #1;
        check("lat_send_off", 32'(send), 32'd0);
`endif
        check("lat_done", 32'(done), 32'd1);
        check("lat_edit_in_done", 32'(edit), 32'd1);
        @(posedge clk); #1;
        check("lat_done_off", 32'(done), 32'd0);
        check("lat_edit_off", 32'(edit), 32'd0);
        check("lat_words", 32'(words_loaded), 32'd1);

        // Reset after two data bytes of the first word
        put(8'hA5, 0);
        put(8'h02, 0);
        put(8'h18, 0);
        put(8'h00, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        clear_mon();
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        check("mrst_edit", 32'(edit), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_code", code, 32'd0);
        check("mrst_line", 32'(line), 32'd0);
        check("mrst_words", 32'(words_loaded), 32'd0);
        check("mrst_rom_clear", 32'(rom_clear), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_error", 32'(error), 32'd0);
        repeat (6) @(negedge clk);
        check("mrst_no_send", 32'(codeq.size()), 32'd0);

        // Table-driven frames
        for (int i = 0; i < nv; i++) begin
            clear_mon();
            for (int k = 0; k < int'(vecs[i].nbytes); k++) begin
                logic [119:0] raw;
                raw = vecs[i].bytes;
                put(raw[119 - 8*k -: 8],
                    (vecs[i].gapmax == 0) ? 0 : int'($urandom_range(int'(vecs[i].gapmax), 0)));
            end
            repeat (6) @(negedge clk);
            check($sformatf("v%0d_nsend", i), 32'(codeq.size()), 32'(vecs[i].nsend));
            for (int k = 0; k < int'(vecs[i].nsend); k++) begin
                if (k < codeq.size()) begin
                    logic [63:0] cs;
                    logic [15:0] ls;
                    cs = vecs[i].codes;
                    ls = vecs[i].lines;
                    check($sformatf("v%0d_code%0d", i, k), codeq[k], cs[63 - 32*k -: 32]);
                    check($sformatf("v%0d_line%0d", i, k), 32'(lineq[k]), 32'(ls[15 - 8*k -: 8]));
                end
            end
            check($sformatf("v%0d_done", i), 32'(done_cnt), 32'(vecs[i].exp_done));
            check($sformatf("v%0d_error", i), 32'(error), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_edit", i), 32'(edit), 32'd0);
            check($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            check($sformatf("v%0d_words", i), 32'(words_loaded), 32'(vecs[i].words));
            check($sformatf("v%0d_clears", i), 32'(clr_cnt), 32'(vecs[i].clears));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
